// File: rtl/pcie_cfg_tlp_responder.sv
// Type-0 configuration request target: executes CfgRd0/CfgWr0 on a DW-addressed
// register port and returns the matching CplD/Cpl as a 4/3-beat stream packet.
module pcie_cfg_tlp_responder #(
    parameter logic [15:0] CPL_ID         = 16'h0030,
    parameter int          REG_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tuser,
    output logic [31:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [REG_ADDR_WIDTH-1:0] cfg_addr,
    output logic                      cfg_rd_en,
    input  logic [31:0]               cfg_rd_data,
    output logic                      cfg_wr_en,
    output logic [31:0]               cfg_wr_data,
    output logic [3:0]                cfg_wr_be,
    output logic [15:0]               drop_count
);

    localparam logic [3:0] S_HDR0   = 4'd0;
    localparam logic [3:0] S_HDR1   = 4'd1;
    localparam logic [3:0] S_HDR2   = 4'd2;
    localparam logic [3:0] S_DATA   = 4'd3;
    localparam logic [3:0] S_ACCESS = 4'd4;
    localparam logic [3:0] S_RDWAIT = 4'd5;
    localparam logic [3:0] S_CPL0   = 4'd6;
    localparam logic [3:0] S_CPL1   = 4'd7;
    localparam logic [3:0] S_CPL2   = 4'd8;
    localparam logic [3:0] S_CPL3   = 4'd9;
    localparam logic [3:0] S_DRAIN  = 4'd10;

    logic [3:0]                r_state;
    logic                      r_live;
    logic                      r_is_rd;
    logic [15:0]               r_req_id;
    logic [7:0]                r_tag;
    logic [3:0]                r_first_be;
    logic [REG_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]               r_wr_data;
    logic [31:0]               r_rd_data;
    logic [15:0]               r_drop_cnt;

    logic [3:0] w_next;
    logic       w_drop;
    logic       w_accept;
    logic       w_beat;
    logic       w_out_hs;
    logic       w_type_rd;
    logic       w_type_wr;
    logic       w_len_ok;
    logic [3:0] w_abort_next;
    logic       w_in_cpl;

    // r_live holds the input side off until the first clock after reset release
    assign w_accept = r_live && ((r_state == S_HDR0) || (r_state == S_HDR1) ||
                                 (r_state == S_HDR2) || (r_state == S_DATA) ||
                                 (r_state == S_DRAIN));
    assign w_beat       = w_accept && s_axis_tvalid;
    assign w_in_cpl     = (r_state == S_CPL0) || (r_state == S_CPL1) ||
                          (r_state == S_CPL2) || (r_state == S_CPL3);
    assign w_out_hs     = w_in_cpl && m_axis_tready;
    assign w_type_rd    = (s_axis_tdata[31:24] == 8'h04);
    assign w_type_wr    = (s_axis_tdata[31:24] == 8'h44);
    assign w_len_ok     = (s_axis_tdata[9:0] == 10'd1);
    assign w_abort_next = s_axis_tlast ? S_HDR0 : S_DRAIN;

    always_comb begin
        w_next = r_state;
        w_drop = 1'b0;
        case (r_state)
            S_HDR0: if (w_beat) begin
                if (s_axis_tuser || s_axis_tlast || !w_len_ok || !(w_type_rd || w_type_wr)) begin
                    w_drop = 1'b1;
                    w_next = w_abort_next;
                end else begin
                    w_next = S_HDR1;
                end
            end
            S_HDR1: if (w_beat) begin
                if (s_axis_tuser || s_axis_tlast) begin
                    w_drop = 1'b1;
                    w_next = w_abort_next;
                end else begin
                    w_next = S_HDR2;
                end
            end
            // HDR2 is the final beat of a read and must not be the final beat of a write
            S_HDR2: if (w_beat) begin
                if (s_axis_tuser || (s_axis_tlast != r_is_rd)) begin
                    w_drop = 1'b1;
                    w_next = w_abort_next;
                end else begin
                    w_next = r_is_rd ? S_ACCESS : S_DATA;
                end
            end
            S_DATA: if (w_beat) begin
                if (s_axis_tuser || !s_axis_tlast) begin
                    w_drop = 1'b1;
                    w_next = w_abort_next;
                end else begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: w_next = r_is_rd ? S_RDWAIT : S_CPL0;
            S_RDWAIT: w_next = S_CPL0;
            S_CPL0:   if (w_out_hs) w_next = S_CPL1;
            S_CPL1:   if (w_out_hs) w_next = S_CPL2;
            S_CPL2:   if (w_out_hs) w_next = r_is_rd ? S_CPL3 : S_HDR0;
            S_CPL3:   if (w_out_hs) w_next = S_HDR0;
            S_DRAIN:  if (w_beat && s_axis_tlast) w_next = S_HDR0;
            default:  w_next = S_HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HDR0;
            r_live     <= 1'b0;
            r_is_rd    <= 1'b0;
            r_req_id   <= 16'h0000;
            r_tag      <= 8'h00;
            r_first_be <= 4'h0;
            r_addr     <= '0;
            r_wr_data  <= 32'h0;
            r_rd_data  <= 32'h0;
            r_drop_cnt <= 16'h0000;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_next;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_beat) begin
                case (r_state)
                    S_HDR0: r_is_rd <= w_type_rd;
                    S_HDR1: begin
                        r_req_id   <= s_axis_tdata[31:16];
                        r_tag      <= s_axis_tdata[15:8];
                        r_first_be <= s_axis_tdata[3:0];
                    end
                    S_HDR2: r_addr    <= REG_ADDR_WIDTH'({s_axis_tdata[11:8], s_axis_tdata[7:2]});
                    S_DATA: r_wr_data <= s_axis_tdata;
                    default: ;
                endcase
            end
            if (r_state == S_RDWAIT) begin
                r_rd_data <= cfg_rd_data;
            end
        end
    end

    always_comb begin
        m_axis_tdata = 32'h0;
        m_axis_tlast = 1'b0;
        case (r_state)
            S_CPL0: m_axis_tdata = r_is_rd ? 32'h4A000001 : 32'h0A000000;
            S_CPL1: m_axis_tdata = {CPL_ID, 3'b000, 1'b0, (r_is_rd ? 12'h004 : 12'h000)};
            S_CPL2: begin
                m_axis_tdata = {r_req_id, r_tag, 1'b0, r_addr[4:0], 2'b00};
                m_axis_tlast = !r_is_rd;
            end
            S_CPL3: begin
                m_axis_tdata = r_rd_data;
                m_axis_tlast = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_axis_tvalid = w_in_cpl;
    assign s_axis_tready = w_accept;
    assign cfg_addr      = r_addr;
    assign cfg_rd_en     = (r_state == S_ACCESS) && r_is_rd;
    // a write with no enabled bytes still completes, it just never touches the register
    assign cfg_wr_en     = (r_state == S_ACCESS) && !r_is_rd && (r_first_be != 4'h0);
    assign cfg_wr_data   = r_wr_data;
    assign cfg_wr_be     = r_first_be;
    assign drop_count    = r_drop_cnt;

endmodule

// File: tb/tb_pcie_cfg_tlp_responder.sv
// Bench for pcie_cfg_tlp_responder: vector table of config TLPs with a completion
// scoreboard, optional output backpressure, and a reset-during-completion sequence.
module tb_pcie_cfg_tlp_responder;

    typedef struct {
        int               n;
        logic [3:0][31:0] dw;
        int               tuser_at;
        logic [31:0]      rd_val;
        int               erd;
        int               ewr;
        logic [9:0]       eaddr;
        logic [3:0]       ebe;
        logic [31:0]      ewd;
        int               ncpl;
        logic [3:0][31:0] cpl;
        int               edrop;
        int               lat;
        int               bp;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [9:0]  cfg_addr;
    logic        cfg_rd_en;
    logic [31:0] cfg_rd_data;
    logic        cfg_wr_en;
    logic [31:0] cfg_wr_data;
    logic [3:0]  cfg_wr_be;
    logic [15:0] drop_count;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    int          tr_mode = 0;
    logic [31:0] cur_rd = 32'h0;
    int          rd_total = 0;
    int          wr_total = 0;
    logic [9:0]  rd_addr_seen = '0;
    logic [9:0]  wr_addr_seen = '0;
    logic [3:0]  wr_be_seen = '0;
    logic [31:0] wr_data_seen = '0;
    vec_t        vecs[14];

    pcie_cfg_tlp_responder #(.CPL_ID(16'h0030), .REG_ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .cfg_addr(cfg_addr), .cfg_rd_en(cfg_rd_en), .cfg_rd_data(cfg_rd_data),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_data(cfg_wr_data), .cfg_wr_be(cfg_wr_be),
        .drop_count(drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // register port model: read data is presented only in the cycle after the strobe
    always @(posedge clk) cfg_rd_data <= cfg_rd_en ? cur_rd : 32'h0BAD0BAD;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_rd_en) begin
                rd_total++;
                rd_addr_seen = cfg_addr;
            end
            if (cfg_wr_en) begin
                wr_total++;
                wr_addr_seen = cfg_addr;
                wr_be_seen   = cfg_wr_be;
                wr_data_seen = cfg_wr_data;
            end
        end
    end

    // output sink: drives m_axis_tready, checks held beats, pops the scoreboard on handshakes
    initial begin
        logic [31:0] hold_d;
        logic        hold_l;
        logic        stalled;
        int          bp_cnt;
        beat_t       b;
        stalled = 1'b0;
        bp_cnt = 0;
        hold_d = 32'h0;
        hold_l = 1'b0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                bp_cnt = 0;
            end else begin
                if (stalled) begin
                    chk("stall_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
                    chk("stall_tdata", m_axis_tdata, hold_d);
                    chk("stall_tlast", {31'b0, m_axis_tlast}, {31'b0, hold_l});
                    chk("stall_s_tready", {31'b0, s_axis_tready}, 32'd0);
                end
                if (tr_mode == 1 && m_axis_tvalid && bp_cnt < 5) begin
                    m_axis_tready = 1'b0;
                    bp_cnt++;
                end else begin
                    m_axis_tready = 1'b1;
                    bp_cnt = 0;
                end
                stalled = m_axis_tvalid && !m_axis_tready;
                hold_d = m_axis_tdata;
                hold_l = m_axis_tlast;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cpl_beat actual=%0h required=none", m_axis_tdata);
                    end else begin
                        b = exp_q.pop_front();
                        chk("cpl_tdata", m_axis_tdata, b.d);
                        chk("cpl_tlast", {31'b0, m_axis_tlast}, {31'b0, b.l});
                    end
                end
            end
        end
    end

    function automatic vec_t mk(input int n, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3, input int tu,
                                input logic [31:0] rdv, input int erd, input int ewr,
                                input logic [9:0] ea, input logic [3:0] eb, input logic [31:0] ew,
                                input int nc, input logic [31:0] c0, input logic [31:0] c1,
                                input logic [31:0] c2, input logic [31:0] c3,
                                input int ed, input int lat, input int bp);
        vec_t v;
        v.n = n;
        v.dw[0] = d0; v.dw[1] = d1; v.dw[2] = d2; v.dw[3] = d3;
        v.tuser_at = tu;
        v.rd_val = rdv;
        v.erd = erd; v.ewr = ewr; v.eaddr = ea; v.ebe = eb; v.ewd = ew;
        v.ncpl = nc;
        v.cpl[0] = c0; v.cpl[1] = c1; v.cpl[2] = c2; v.cpl[3] = c3;
        v.edrop = ed; v.lat = lat; v.bp = bp;
        return v;
    endfunction

    task automatic send(input vec_t v);
        int w;
        for (int i = 0; i < v.n; i++) begin
            s_axis_tdata  = v.dw[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == v.n - 1);
            s_axis_tuser  = (i == v.tuser_at);
            w = 0;
            while (!s_axis_tready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                checks++;
                errors++;
                $display("FAIL s_tready_timeout actual=0 required=1 beat=%0d", i);
                break;
            end
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic push_cpl(input vec_t v);
        beat_t b;
        for (int i = 0; i < v.ncpl; i++) begin
            b.d = v.cpl[i];
            b.l = (i == v.ncpl - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] d0;
        int rd0, wr0, k;
        d0 = drop_count;
        rd0 = rd_total;
        wr0 = wr_total;
        cur_rd = v.rd_val;
        tr_mode = v.bp;
        push_cpl(v);
        send(v);
        if (v.lat >= 0) begin
            k = 0;
            while (!m_axis_tvalid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("cpl_latency", k, v.lat);
        end
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("cpl_beats_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        chk("rd_strobes", rd_total - rd0, v.erd);
        chk("wr_strobes", wr_total - wr0, v.ewr);
        if (v.erd != 0) chk("rd_addr", {22'b0, rd_addr_seen}, {22'b0, v.eaddr});
        if (v.ewr != 0) begin
            chk("wr_addr", {22'b0, wr_addr_seen}, {22'b0, v.eaddr});
            chk("wr_be", {28'b0, wr_be_seen}, {28'b0, v.ebe});
            chk("wr_data", wr_data_seen, v.ewd);
        end
        chk("drop_count", {16'b0, drop_count}, {16'b0, d0} + v.edrop);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        s_axis_tdata = 32'h0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tuser = 1'b0;

        //          n  dw0          dw1          dw2          dw3          tu rd_val       rd wr addr    be    wdata        nc cpl0         cpl1         cpl2         cpl3         drop lat bp
        vecs[0]  = mk(3, 32'h04000001, 32'h01005A0F, 32'h00000010, 32'h0,       -1, 32'hDEADBEEF, 1, 0, 10'h004, 4'h0, 32'h0,        4, 32'h4A000001, 32'h00300004, 32'h01005A10, 32'hDEADBEEF, 0, 2, 0);
        vecs[1]  = mk(4, 32'h44000001, 32'h0100220F, 32'h00000008, 32'h12345678, -1, 32'h0,       0, 1, 10'h002, 4'hF, 32'h12345678, 3, 32'h0A000000, 32'h00300000, 32'h01002208, 32'h0,        0, 1, 0);
        vecs[2]  = mk(3, 32'h00000001, 32'h11111111, 32'h22222222, 32'h0,       -1, 32'h0,        0, 0, 10'h000, 4'h0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        1, -1, 0);
        vecs[3]  = vecs[0];
        vecs[4]  = mk(3, 32'h04000001, 32'h01005A0F, 32'h00000010, 32'h0,       -1, 32'h13579BDF, 1, 0, 10'h004, 4'h0, 32'h0,        4, 32'h4A000001, 32'h00300004, 32'h01005A10, 32'h13579BDF, 0, 2, 1);
        vecs[5]  = mk(4, 32'h44000001, 32'hABCD1106, 32'h00000104, 32'hCAFEF00D, -1, 32'h0,       0, 1, 10'h041, 4'h6, 32'hCAFEF00D, 3, 32'h0A000000, 32'h00300000, 32'hABCD1104, 32'h0,        0, 1, 1);
        vecs[6]  = mk(3, 32'h44000001, 32'h0100220F, 32'h00000008, 32'h0,       -1, 32'h0,        0, 0, 10'h000, 4'h0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        1, -1, 0);
        vecs[7]  = mk(3, 32'h04000001, 32'h01005A0F, 32'h00000010, 32'h0,        1, 32'h0,        0, 0, 10'h000, 4'h0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        1, -1, 0);
        vecs[8]  = mk(3, 32'h04000001, 32'h12340703, 32'h00000F3C, 32'h0,       -1, 32'hA5A50001, 1, 0, 10'h3CF, 4'h0, 32'h0,        4, 32'h4A000001, 32'h00300004, 32'h1234073C, 32'hA5A50001, 0, 2, 0);
        vecs[9]  = mk(4, 32'h44000001, 32'h01003300, 32'h0000000C, 32'h11112222, -1, 32'h0,       0, 0, 10'h000, 4'h0, 32'h0,        3, 32'h0A000000, 32'h00300000, 32'h0100330C, 32'h0,        0, 1, 0);
        vecs[10] = mk(3, 32'h04000002, 32'h01005A0F, 32'h00000010, 32'h0,       -1, 32'h0,        0, 0, 10'h000, 4'h0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        1, -1, 0);
        vecs[11] = mk(4, 32'h04000001, 32'h01005A0F, 32'h00000010, 32'h0,       -1, 32'h0,        0, 0, 10'h000, 4'h0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        1, -1, 0);
        vecs[12] = mk(4, 32'h44000001, 32'h0100220F, 32'h00000008, 32'h12345678,  3, 32'h0,       0, 0, 10'h000, 4'h0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        1, -1, 0);
        vecs[13] = mk(3, 32'h04000001, 32'h0200C10F, 32'h0000007C, 32'h0,       -1, 32'h00C0FFEE, 1, 0, 10'h01F, 4'h0, 32'h0,        4, 32'h4A000001, 32'h00300004, 32'h0200C17C, 32'h00C0FFEE, 0, 2, 0);

        repeat (3) @(negedge clk);
        chk("rst_m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        chk("rst_m_tdata", m_axis_tdata, 32'd0);
        chk("rst_m_tlast", {31'b0, m_axis_tlast}, 32'd0);
        chk("rst_s_tready", {31'b0, s_axis_tready}, 32'd0);
        chk("rst_rd_en", {31'b0, cfg_rd_en}, 32'd0);
        chk("rst_wr_en", {31'b0, cfg_wr_en}, 32'd0);
        chk("rst_cfg_addr", {22'b0, cfg_addr}, 32'd0);
        chk("rst_drop_count", {16'b0, drop_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_s_tready", {31'b0, s_axis_tready}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // reset asserted while the second completion DW is being held
        tr_mode = 1;
        cur_rd = 32'h77665544;
        push_cpl(vecs[0]);
        send(vecs[0]);
        k = 0;
        while (!(m_axis_tvalid && m_axis_tdata == 32'h00300004) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            checks++;
            errors++;
            $display("FAIL cpl1_wait_timeout actual=none required=00300004");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        chk("midrst_m_tdata", m_axis_tdata, 32'd0);
        chk("midrst_drop_count", {16'b0, drop_count}, 32'd0);
        exp_q.delete();
        tr_mode = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
